hdlc_flag_framer_tx: RTL and testbench

//  Serial frame transmitter, the sending end of the 0111_1110 flag-detector link.
//  - Accepts payload bytes over a valid/ready handshake.
//  - Emits one bit per clk: opening flag, bit-stuffed payload (LSB first), closing flag.
//  - On payload underrun, emits an abort run of ones instead of a closing flag.

---
 rtl/hdlc_flag_framer_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_hdlc_flag_framer_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_flag_framer_tx.sv
// hdlc_flag_framer_tx
//   Bit-serial HDLC-style frame transmitter. It takes payload bytes over a
//   valid/ready handshake and sends one bit per clock: an opening flag, then
//   the payload LSB first with a zero stuffed after every run of STUFF_RUN
//   ones, then a closing flag. If the payload runs dry before a byte marked
//   last, it sends ABORT_ONES ones instead of the closing flag.
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   din[7:0]   in   payload byte
//   din_valid  in   din is valid
//   din_last   in   din is the final byte of the frame
//   din_ready  out  holding register empty (transfer = din_valid & din_ready)
//   so         out  serial bit, registered (1 when idle)
//   so_valid   out  so carries frame/abort bits
//   busy       out  transmitter not idle
//   done       out  one-cycle pulse with the last closing-flag bit
//   abort      out  one-cycle pulse with the last abort bit
module hdlc_flag_framer_tx #(
  parameter logic [7:0] FLAG       = 8'h7E,
  parameter int         STUFF_RUN  = 5,
  parameter int         ABORT_ONES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  input  logic       din_last,
  output logic       din_ready,
  output logic       so,
  output logic       so_valid,
  output logic       busy,
  output logic       done,
  output logic       abort
);

  localparam logic [2:0] STUFF_RUN_C  = 3'(STUFF_RUN);
  localparam logic [2:0] ABORT_LAST_C = 3'(ABORT_ONES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OPEN  = 3'd1,
    S_DATA  = 3'd2,
    S_STUFF = 3'd3,
    S_CLOSE = 3'd4,
    S_ABORT = 3'd5
  } state_t;

  // State describes the bit that is on so during the current cycle; the
  // combinational block picks the bit (and state) for the following cycle.
  state_t     state_r, state_nxt;
  logic [2:0] bit_cnt_r, bit_nxt;
  logic [2:0] ones_r, ones_nxt;      // consecutive payload ones, including the bit on so
  logic [7:0] byte_r;                // byte currently being serialised
  logic       byte_last_r;
  logic [7:0] hold_data_r;
  logic       hold_last_r;
  logic       hold_full_r;
  logic       so_r, so_nxt;
  logic       busy_r, done_r, abort_r;
  logic       done_nxt, abort_nxt;
  logic       unload_s, load_s, byte_end_s;

  function automatic logic [2:0] next_ones(input logic b, input logic [2:0] n);
    return b ? (n + 3'd1) : 3'd0;
  endfunction

  assign load_s    = din_valid & ~hold_full_r;
  assign din_ready = ~hold_full_r;
  assign so        = so_r;
  assign so_valid  = busy_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign abort     = abort_r;

  // Next-state, next-bit and holding-register unload decision.
  always_comb begin
    state_nxt  = state_r;
    bit_nxt    = bit_cnt_r;
    ones_nxt   = ones_r;
    so_nxt     = 1'b1;
    unload_s   = 1'b0;
    byte_end_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        ones_nxt = 3'd0;
        // A byte already held (e.g. after an abort) also starts a frame.
        if (hold_full_r | din_valid) begin
          state_nxt = S_OPEN;
          bit_nxt   = 3'd0;
          so_nxt    = FLAG[0];
        end else begin
          so_nxt = 1'b1;
        end
      end
      S_OPEN: begin
        ones_nxt = 3'd0;
        if (bit_cnt_r == 3'd7) begin
          unload_s  = 1'b1;
          state_nxt = S_DATA;
          bit_nxt   = 3'd0;
          so_nxt    = hold_data_r[0];
          ones_nxt  = next_ones(hold_data_r[0], 3'd0);
        end else begin
          bit_nxt = bit_cnt_r + 3'd1;
          so_nxt  = FLAG[bit_cnt_r + 3'd1];
        end
      end
      S_DATA: begin
        if (ones_r == STUFF_RUN_C) begin
          // Shifter holds its position while the stuffed zero goes out.
          state_nxt = S_STUFF;
          so_nxt    = 1'b0;
          ones_nxt  = 3'd0;
        end else if (bit_cnt_r == 3'd7) begin
          byte_end_s = 1'b1;
        end else begin
          bit_nxt  = bit_cnt_r + 3'd1;
          so_nxt   = byte_r[bit_cnt_r + 3'd1];
          ones_nxt = next_ones(byte_r[bit_cnt_r + 3'd1], ones_r);
        end
      end
      S_STUFF: begin
        ones_nxt = 3'd0;
        if (bit_cnt_r == 3'd7) begin
          byte_end_s = 1'b1;
        end else begin
          state_nxt = S_DATA;
          bit_nxt   = bit_cnt_r + 3'd1;
          so_nxt    = byte_r[bit_cnt_r + 3'd1];
          ones_nxt  = next_ones(byte_r[bit_cnt_r + 3'd1], 3'd0);
        end
      end
      S_CLOSE: begin
        ones_nxt = 3'd0;
        if (bit_cnt_r == 3'd7) begin
          state_nxt = S_IDLE;
          bit_nxt   = 3'd0;
          so_nxt    = 1'b1;
        end else begin
          bit_nxt = bit_cnt_r + 3'd1;
          so_nxt  = FLAG[bit_cnt_r + 3'd1];
        end
      end
      S_ABORT: begin
        ones_nxt = 3'd0;
        so_nxt   = 1'b1;
        if (bit_cnt_r == ABORT_LAST_C) begin
          state_nxt = S_IDLE;
          bit_nxt   = 3'd0;
        end else begin
          bit_nxt = bit_cnt_r + 3'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        bit_nxt   = 3'd0;
        ones_nxt  = 3'd0;
        so_nxt    = 1'b1;
      end
    endcase

    // Byte boundary: close, continue seamlessly with the held byte (the ones
    // run carries across the boundary), or abort on underrun.
    if (byte_end_s) begin
      bit_nxt = 3'd0;
      if (byte_last_r) begin
        state_nxt = S_CLOSE;
        so_nxt    = FLAG[0];
        ones_nxt  = 3'd0;
      end else if (hold_full_r) begin
        unload_s  = 1'b1;
        state_nxt = S_DATA;
        so_nxt    = hold_data_r[0];
        ones_nxt  = next_ones(hold_data_r[0], ones_nxt);
      end else begin
        state_nxt = S_ABORT;
        so_nxt    = 1'b1;
        ones_nxt  = 3'd0;
      end
    end else begin
      bit_nxt = bit_nxt;
    end

    done_nxt  = (state_nxt == S_CLOSE) && (bit_nxt == 3'd7);
    abort_nxt = (state_nxt == S_ABORT) && (bit_nxt == ABORT_LAST_C);
  end

  // FSM state, counters and registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      bit_cnt_r <= 3'd0;
      ones_r    <= 3'd0;
      so_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      abort_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bit_cnt_r <= bit_nxt;
      ones_r    <= ones_nxt;
      so_r      <= so_nxt;
      busy_r    <= (state_nxt != S_IDLE);
      done_r    <= done_nxt;
      abort_r   <= abort_nxt;
    end
  end

  // Holding register and serialiser byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data_r <= 8'h00;
      hold_last_r <= 1'b0;
      hold_full_r <= 1'b0;
      byte_r      <= 8'h00;
      byte_last_r <= 1'b0;
    end else begin
      if (load_s) begin
        hold_data_r <= din;
        hold_last_r <= din_last;
      end
      hold_full_r <= load_s | (hold_full_r & ~unload_s);
      if (unload_s) begin
        byte_r      <= hold_data_r;
        byte_last_r <= hold_last_r;
      end
    end
  end

endmodule

// File: tb/tb_hdlc_flag_framer_tx.sv
// tb_hdlc_flag_framer_tx
//   Scoreboard bench: stimulus pushes the expected serial bit stream (with
//   done/abort markers) into a queue; an independent monitor pops one entry
//   per so_valid cycle and also runs a flag detector on so.
module tb_hdlc_flag_framer_tx;

  localparam logic [7:0] FLAG_C = 8'h7E;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       din_valid;
  logic       din_last;
  logic       din_ready;
  logic       so;
  logic       so_valid;
  logic       busy;
  logic       done;
  logic       abort;

  hdlc_flag_framer_tx dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .so        (so),
    .so_valid  (so_valid),
    .busy      (busy),
    .done      (done),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic d;
    logic a;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] frame_q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         frames_exp = 0;
  int         closing_hits = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Hand-written expected stream: '0'/'1' characters, marker on the last bit.
  task automatic push_str(input string s, input logic end_done, input logic end_abort);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.b = (s[i] == 8'h31);
      e.d = end_done && (i == s.len() - 1);
      e.a = end_abort && (i == s.len() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_bit(input logic b, input logic d);
    exp_t e;
    e.b = b;
    e.d = d;
    e.a = 1'b0;
    exp_q.push_back(e);
  endtask

  // Reference stream for frame_q: flag, stuffed payload, flag.
  task automatic push_frame_model();
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) push_bit(FLAG_C[i], 1'b0);
    foreach (frame_q[j]) begin
      for (int i = 0; i < 8; i++) begin
        push_bit(frame_q[j][i], 1'b0);
        ones = frame_q[j][i] ? ones + 1 : 0;
        if (ones == 5) begin
          push_bit(1'b0, 1'b0);
          ones = 0;
        end
      end
    end
    for (int i = 0; i < 8; i++) push_bit(FLAG_C[i], i == 7);
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input logic l);
    logic rdy;
    logic ok;
    ok = 1'b0;
    din = b;
    din_last = l;
    din_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      rdy = din_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    if (!ok) chk("din_ready_wait", 32'(din_ready), 32'd1);
  endtask

  task automatic wait_drain(input int bound);
    for (int k = 0; k < bound; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: scoreboard pop/compare plus flag detector on the line.
  initial begin
    logic [7:0] det_sr;
    logic       hit;
    logic       gap_pending;
    int         fidx;
    exp_t       e;
    det_sr = 8'hFF;
    gap_pending = 1'b0;
    fidx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        det_sr = 8'hFF;
        fidx = 0;
        gap_pending = 1'b0;
      end else begin
        det_sr = {so, det_sr[7:1]};
        hit = (det_sr == FLAG_C) && so_valid;
        if (gap_pending) begin
          chk("idle_gap", 32'({so_valid, so}), 32'd1);
          gap_pending = 1'b0;
        end
        if (so_valid) begin
          if (hit && fidx != 7) begin
            chk("hit_on_done", 32'(done), 32'd1);
            closing_hits++;
          end
          if (exp_q.size() == 0) begin
            chk("unexpected_valid", 32'(so_valid), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("so", 32'(so), 32'(e.b));
            chk("done", 32'(done), 32'(e.d));
            chk("abort", 32'(abort), 32'(e.a));
            if (e.d) chk("det_at_done", 32'(hit), 32'd1);
            if (e.d || e.a) gap_pending = 1'b1;
          end
          fidx++;
        end else begin
          fidx = 0;
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    din_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_so", 32'(so), 32'd1);
    chk("rst_so_valid", 32'(so_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1) 0x00 with last
    push_str({"01111110", "00000000", "01111110"}, 1'b1, 1'b0);
    frames_exp++;
    send_byte(8'h00, 1'b1);
    wait_drain(200);

    // 2) 0xFF with last: stuffed zero after five ones
    push_str({"01111110", "111110111", "01111110"}, 1'b1, 1'b0);
    frames_exp++;
    send_byte(8'hFF, 1'b1);
    wait_drain(200);

    // 3) 0x1F, 0xF8 back-to-back: stuff mid-byte and at the end of byte 2
    push_str({"01111110", "111110000", "000111110", "01111110"}, 1'b1, 1'b0);
    frames_exp++;
    send_byte(8'h1F, 1'b0);
    send_byte(8'hF8, 1'b1);
    wait_drain(200);

    // 4) 0xA5 without last, then underrun -> abort
    push_str({"01111110", "10100101", "1111111"}, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b0);
    wait_drain(200);

    // 5) Reset during the third payload bit
    push_str({"01111110", "00000000", "01111110"}, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_so", 32'(so), 32'd1);
    chk("midrst_so_valid", 32'(so_valid), 32'd0);
    chk("midrst_din_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_so", 32'(so), 32'd1);
    chk("postrst_so_valid", 32'(so_valid), 32'd0);
    chk("postrst_din_ready", 32'(din_ready), 32'd1);
    @(negedge clk);
    push_str({"01111110", "00000000", "01111110"}, 1'b1, 1'b0);
    frames_exp++;
    send_byte(8'h00, 1'b1);
    wait_drain(200);

    // 6) 200 random frames, sent back-to-back
    for (int f = 0; f < 200; f++) begin
      int n;
      n = $urandom_range(1, 16);
      frame_q.delete();
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) == 0) frame_q.push_back(8'hFF);
        else frame_q.push_back(8'($urandom));
      end
      push_frame_model();
      frames_exp++;
      for (int j = 0; j < n; j++) send_byte(frame_q[j], j == n - 1);
    end
    wait_drain(3000);

    chk("closing_hits", 32'(closing_hits), 32'(frames_exp));
    chk("final_idle", 32'({busy, so_valid, so}), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
